// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and coin codes for the vending controller
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vend_state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_50   = 2'b01;
    localparam logic [1:0] COIN_100  = 2'b10;

    // Credit increment in 50-cent units; 11 is treated as no coin.
    function automatic logic [1:0] coin_inc(input logic [1:0] code);
        case (code)
            COIN_50:   coin_inc = 2'd1;
            COIN_100:  coin_inc = 2'd2;
            COIN_NONE: coin_inc = 2'd0;
            default:   coin_inc = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_pulser.sv
// rtl/vend_change_pulser.sv - eject pulse train generator, one high/low pulse per loaded unit
module vend_change_pulser #(
    parameter int unsigned CHANGE_PULSE_CYC = 4,
    parameter int unsigned UW               = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [UW-1:0] units_i,
    output logic          eject_o,
    output logic          dec_o,
    output logic          done_o
);

    localparam int unsigned CNTW = (CHANGE_PULSE_CYC > 1) ? $clog2(CHANGE_PULSE_CYC) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CHANGE_PULSE_CYC - 1);

    logic            active_q, active_d;
    logic            high_q, high_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [UW-1:0]   rem_q, rem_d;
    logic            phase_end;

    always_comb begin
        active_d  = active_q;
        high_d    = high_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        phase_end = active_q && (cnt_q == CNT_LAST);
        dec_o     = phase_end && high_q;
        // An idle pulser reports done so a zero-unit load cannot stall the caller.
        done_o    = active_q ? (phase_end && !high_q && (rem_q == '0)) : 1'b1;
        if (load_i) begin
            active_d = (units_i != '0);
            high_d   = (units_i != '0);
            cnt_d    = '0;
            rem_d    = units_i;
        end else if (active_q) begin
            if (phase_end) begin
                cnt_d = '0;
                if (high_q) begin
                    high_d = 1'b0;
                    rem_d  = rem_q - 1'b1;
                end else if (rem_q == '0) begin
                    active_d = 1'b0;
                end else begin
                    high_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            high_q   <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
        end else begin
            active_q <= active_d;
            high_q   <= high_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
        end
    end

    assign eject_o = high_q;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// rtl/vend_dispense_ctrl.sv - vending credit/dispense/change sequencer; VEND_TIMEOUT_EN adds idle auto-refund
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned PRICE            = 3,
    parameter int unsigned MAX_CREDIT       = 6,
    parameter int unsigned CHANGE_PULSE_CYC = 4,
    parameter int unsigned TIMEOUT_CYC      = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        coin_i,
    input  logic                              sel_i,
    input  logic                              cancel_i,
    input  logic                              disp_ack_i,
    output logic                              disp_req_o,
    output logic                              eject_o,
    output logic                              coin_reject_o,
    output logic [$clog2(MAX_CREDIT+1)-1:0]   credit_o,
    output logic                              busy_o
);

    localparam int unsigned CW = $clog2(MAX_CREDIT + 1);

    vend_state_t   state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          reject_q, reject_d;

    logic [1:0]    inc;
    logic          coin_vld, coin_ok, afford;
    logic [CW:0]   sum, base, after_buy;
    logic          pulse_load, pulse_dec, pulse_done;
    logic          tmo_hit;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          activity;

    // Counter only runs in CREDIT, so it is already zero on every entry.
    always_comb begin
        tmo_d    = '0;
        tmo_hit  = 1'b0;
        activity = coin_vld || sel_i || cancel_i;
        if (state_q == CREDIT && !activity) begin
            tmo_d   = tmo_q + 1'b1;
            tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic [31:0] tmo_unused;
    assign tmo_unused = TIMEOUT_CYC;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        pulse_load = 1'b0;
        inc        = coin_inc(coin_i);
        coin_vld   = (inc != 2'd0);
        sum        = {1'b0, credit_q} + (CW+1)'(inc);
        coin_ok    = coin_vld && (state_q == IDLE || state_q == CREDIT)
                     && (sum <= (CW+1)'(MAX_CREDIT));
        reject_d   = coin_vld && !coin_ok;
        base       = coin_ok ? sum : {1'b0, credit_q};
        // Buy decision uses the credit held before this cycle's coin.
        afford     = ({1'b0, credit_q} >= (CW+1)'(PRICE));
        after_buy  = base - (CW+1)'(PRICE);
        case (state_q)
            IDLE: begin
                if (coin_ok) begin
                    credit_d = base[CW-1:0];
                    state_d  = CREDIT;
                end
            end
            CREDIT: begin
                credit_d = base[CW-1:0];
                if (sel_i && afford) begin
                    credit_d = after_buy[CW-1:0];
                    state_d  = DISPENSE;
                end else if (cancel_i || tmo_hit) begin
                    state_d    = CHANGE;
                    pulse_load = 1'b1;
                end
            end
            DISPENSE: begin
                if (disp_ack_i) begin
                    if (credit_q != '0) begin
                        state_d    = CHANGE;
                        pulse_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CHANGE: begin
                if (pulse_dec) begin
                    credit_d = credit_q - 1'b1;
                end
                if (pulse_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    vend_change_pulser #(
        .CHANGE_PULSE_CYC (CHANGE_PULSE_CYC),
        .UW               (CW)
    ) u_pulser (
        .clk     (clk),
        .rst     (rst),
        .load_i  (pulse_load),
        .units_i (credit_d),
        .eject_o (eject_o),
        .dec_o   (pulse_dec),
        .done_o  (pulse_done)
    );

    assign disp_req_o    = (state_q == DISPENSE);
    assign busy_o        = (state_q == DISPENSE) || (state_q == CHANGE);
    assign coin_reject_o = reject_q;
    assign credit_o      = credit_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb/tb_vend_dispense_ctrl.sv - directed self-checking bench for vend_dispense_ctrl
module tb_vend_dispense_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] coin_i;
    logic       sel_i;
    logic       cancel_i;
    logic       disp_ack_i;
    logic       disp_req_o;
    logic       eject_o;
    logic       coin_reject_o;
    logic [2:0] credit_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;
    logic eject_seen;

    vend_dispense_ctrl #(
        .PRICE            (3),
        .MAX_CREDIT       (6),
        .CHANGE_PULSE_CYC (4),
        .TIMEOUT_CYC      (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .coin_i        (coin_i),
        .sel_i         (sel_i),
        .cancel_i      (cancel_i),
        .disp_ack_i    (disp_ack_i),
        .disp_req_o    (disp_req_o),
        .eject_o       (eject_o),
        .coin_reject_o (coin_reject_o),
        .credit_o      (credit_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (eject_o) eject_seen = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; coin_i = 2'b00; sel_i = 1'b0; cancel_i = 1'b0; disp_ack_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        eject_seen = 1'b0;
    endtask

    task automatic coin(input logic [1:0] c);
        coin_i = c;
        tick();
        coin_i = 2'b00;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (credit_o !== 3'd0) begin bad++; $display("FAIL reset_credit got=%0d exp=0", credit_o); end
        total++; if ({disp_req_o, eject_o, coin_reject_o, busy_o} !== 4'b0000) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0000", {disp_req_o, eject_o, coin_reject_o, busy_o}); end
    endtask

    task automatic test_buy_exact();
        do_reset();
        coin(2'b01);
        total++; if (credit_o !== 3'd1) begin bad++; $display("FAIL buy_credit1 got=%0d exp=1", credit_o); end
        coin(2'b10);
        total++; if (credit_o !== 3'd3) begin bad++; $display("FAIL buy_credit3 got=%0d exp=3", credit_o); end
        sel_i = 1'b1; tick(); sel_i = 1'b0;
        total++; if ({disp_req_o, busy_o, credit_o} !== {2'b11, 3'd0}) begin
            bad++; $display("FAIL buy_dispense got req/busy/credit=%b/%b/%0d exp=1/1/0", disp_req_o, busy_o, credit_o); end
        for (int i = 0; i < 4; i++) tick();
        total++; if (disp_req_o !== 1'b1) begin bad++; $display("FAIL buy_req_held got=%b exp=1", disp_req_o); end
        disp_ack_i = 1'b1; tick(); disp_ack_i = 1'b0;
        total++; if ({disp_req_o, busy_o, credit_o} !== {2'b00, 3'd0}) begin
            bad++; $display("FAIL buy_idle got req/busy/credit=%b/%b/%0d exp=0/0/0", disp_req_o, busy_o, credit_o); end
        tick();
        total++; if (eject_seen !== 1'b0) begin bad++; $display("FAIL buy_no_eject got=%b exp=0", eject_seen); end
    endtask

    task automatic test_buy_change();
        logic [7:0] pat;
        logic       busy_all;
        do_reset();
        coin(2'b10);
        coin(2'b10);
        total++; if (credit_o !== 3'd4) begin bad++; $display("FAIL chg_credit4 got=%0d exp=4", credit_o); end
        sel_i = 1'b1; tick(); sel_i = 1'b0;
        total++; if ({busy_o, credit_o} !== {1'b1, 3'd1}) begin
            bad++; $display("FAIL chg_after_sel got busy/credit=%b/%0d exp=1/1", busy_o, credit_o); end
        disp_ack_i = 1'b1; tick(); disp_ack_i = 1'b0;
        pat = 8'h00; busy_all = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pat[i] = eject_o;
            if (!busy_o) busy_all = 1'b0;
            if (i == 3) begin
                total++; if (credit_o !== 3'd1) begin bad++; $display("FAIL chg_credit_before_fall got=%0d exp=1", credit_o); end
            end
            if (i == 4) begin
                total++; if (credit_o !== 3'd0) begin bad++; $display("FAIL chg_credit_after_fall got=%0d exp=0", credit_o); end
            end
            tick();
        end
        total++; if (pat !== 8'b0000_1111) begin bad++; $display("FAIL chg_pulse_shape got=%b exp=00001111", pat); end
        total++; if (busy_all !== 1'b1) begin bad++; $display("FAIL chg_busy got=%b exp=1", busy_all); end
        total++; if ({busy_o, eject_o, credit_o} !== {2'b00, 3'd0}) begin
            bad++; $display("FAIL chg_idle got busy/eject/credit=%b/%b/%0d exp=0/0/0", busy_o, eject_o, credit_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        coin(2'b10); coin(2'b10); coin(2'b10);
        total++; if (credit_o !== 3'd6) begin bad++; $display("FAIL ovf_credit6 got=%0d exp=6", credit_o); end
        total++; if (coin_reject_o !== 1'b0) begin bad++; $display("FAIL ovf_no_reject got=%b exp=0", coin_reject_o); end
        coin(2'b01);
        total++; if ({coin_reject_o, credit_o} !== {1'b1, 3'd6}) begin
            bad++; $display("FAIL ovf_reject got rej/credit=%b/%0d exp=1/6", coin_reject_o, credit_o); end
        tick();
        total++; if (coin_reject_o !== 1'b0) begin bad++; $display("FAIL ovf_reject_width got=%b exp=0", coin_reject_o); end
    endtask

    task automatic test_sel_with_coin();
        do_reset();
        coin(2'b10);
        sel_i = 1'b1; coin_i = 2'b01; tick(); coin_i = 2'b00;
        total++; if ({disp_req_o, credit_o} !== {1'b0, 3'd3}) begin
            bad++; $display("FAIL selcoin_same got req/credit=%b/%0d exp=0/3", disp_req_o, credit_o); end
        tick(); sel_i = 1'b0;
        total++; if ({disp_req_o, credit_o} !== {1'b1, 3'd0}) begin
            bad++; $display("FAIL selcoin_next got req/credit=%b/%0d exp=1/0", disp_req_o, credit_o); end
    endtask

    task automatic test_sel_cancel();
        do_reset();
        cancel_i = 1'b1; tick(); cancel_i = 1'b0;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL cancel_idle got busy=%b exp=0", busy_o); end
        coin(2'b10); coin(2'b01);
        sel_i = 1'b1; cancel_i = 1'b1; tick(); sel_i = 1'b0; cancel_i = 1'b0;
        total++; if ({disp_req_o, eject_o, credit_o} !== {2'b10, 3'd0}) begin
            bad++; $display("FAIL selcancel got req/eject/credit=%b/%b/%0d exp=1/0/0", disp_req_o, eject_o, credit_o); end
    endtask

    task automatic test_refund();
        int pulses;
        int highs;
        logic prev;
        do_reset();
        coin(2'b10); coin(2'b10); coin(2'b01);
        total++; if (credit_o !== 3'd5) begin bad++; $display("FAIL ref_credit5 got=%0d exp=5", credit_o); end
        cancel_i = 1'b1; tick(); cancel_i = 1'b0;
        pulses = 0; highs = 0; prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (eject_o && !prev) pulses++;
            if (eject_o) highs++;
            prev = eject_o;
            if (i == 11) begin
                total++; if (coin_reject_o !== 1'b1) begin bad++; $display("FAIL ref_coin_reject got=%b exp=1", coin_reject_o); end
            end
            coin_i = (i == 10) ? 2'b01 : 2'b00;
            tick();
        end
        coin_i = 2'b00;
        total++; if (pulses != 5 || highs != 20) begin
            bad++; $display("FAIL ref_pulses got pulses/high=%0d/%0d exp=5/20", pulses, highs); end
        total++; if ({busy_o, credit_o} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL ref_idle got busy/credit=%b/%0d exp=0/0", busy_o, credit_o); end
        coin(2'b10);
        cancel_i = 1'b1; tick(); cancel_i = 1'b0;
        tick();
        total++; if (eject_o !== 1'b1) begin bad++; $display("FAIL ref_mid_pulse got=%b exp=1", eject_o); end
        rst = 1'b1;
        #1;
        total++; if ({eject_o, busy_o, credit_o} !== {2'b00, 3'd0}) begin
            bad++; $display("FAIL ref_async_rst got eject/busy/credit=%b/%b/%0d exp=0/0/0", eject_o, busy_o, credit_o); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        coin(2'b01);
`ifdef VEND_TIMEOUT_EN
        for (int i = 0; i < 19; i++) tick();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL tmo_early got busy=%b exp=0", busy_o); end
        tick();
        total++; if ({busy_o, eject_o} !== 2'b11) begin
            bad++; $display("FAIL tmo_refund got busy/eject=%b/%b exp=1/1", busy_o, eject_o); end
        for (int i = 0; i < 8; i++) tick();
        total++; if ({busy_o, credit_o} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL tmo_done got busy/credit=%b/%0d exp=0/0", busy_o, credit_o); end
`else
        for (int i = 0; i < 100; i++) tick();
        total++; if ({busy_o, credit_o} !== {1'b0, 3'd1}) begin
            bad++; $display("FAIL tmo_held got busy/credit=%b/%0d exp=0/1", busy_o, credit_o); end
`endif
    endtask

    initial begin
        rst = 1'b1; coin_i = 2'b00; sel_i = 1'b0; cancel_i = 1'b0; disp_ack_i = 1'b0;
        eject_seen = 1'b0;
        test_reset();
        test_buy_exact();
        test_buy_change();
        test_overflow();
        test_sel_with_coin();
        test_sel_cancel();
        test_refund();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
- Sequencing controller for the vending datapath.
- Accumulates coin credit in 50-cent units and accepts a buy request when credit covers the price.
- Drives the product dispenser through a req/ack handshake, then pays out remaining credit as change pulses to the coin ejector.
- Sits between the coin acceptor and user buttons on ui_in and the dispenser/ejector outputs on uo_out in the top-level wrapper.

Parameters:
- PRICE, 3: product price in 50-cent units (3 = 1.50 EUR); must be >= 1 and <= MAX_CREDIT.
- MAX_CREDIT, 6: maximum credit held, in 50-cent units.
- CHANGE_PULSE_CYC, 4: eject_o high time per returned coin, and the low gap after it, in cycles.
- TIMEOUT_CYC, 1000: idle cycles before auto-refund; used only with VEND_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- coin_i  in  2  one-cycle coin code: 01 = 50 cent, 10 = 1 euro; 00 and 11 = no coin.
- sel_i  in  1  buy request, sampled every cycle.
- cancel_i  in  1  refund request, sampled every cycle.
- disp_ack_i  in  1  dispenser acknowledge.
- disp_req_o  out  1  dispense request to the dispenser.
- eject_o  out  1  coin-eject pulse; one pulse per 50 cent returned.
- coin_reject_o  out  1  one-cycle pulse when a coin is refused.
- credit_o  out  CW  current credit in 50-cent units; CW = $clog2(MAX_CREDIT+1).
- busy_o  out  1  high in DISPENSE or CHANGE.

Behaviour:
- Reset: state IDLE; credit 0; pulse and timeout counters 0; all outputs 0. Reset takes effect immediately, mid-operation included. disp_req_o and eject_o drop asynchronously; held credit is discarded.
- States and exits:
  - IDLE: credit == 0. First accepted coin -> CREDIT.
  - CREDIT: 0 < credit < MAX_CREDIT+1. Exits: sel -> DISPENSE, cancel -> CHANGE.
  - DISPENSE: entered when sel_i = 1 and the registered credit >= PRICE. On the entry edge, credit <= credit - PRICE.
  - CHANGE: returns remaining credit as eject pulses.
- Coin acceptance, IDLE and CREDIT only:
  - Increment is 1 for code 01 and 2 for code 10.
  - If credit + increment > MAX_CREDIT: credit unchanged; coin_reject_o = 1 on the following cycle for exactly one cycle.
  - Any coin in DISPENSE or CHANGE is rejected the same way.
- Same-cycle events:
  - sel and a coin: the coin is accepted or rejected first against the old credit. sel is judged on the old credit. Next credit = credit + inc - PRICE. The overflow check uses credit + inc only.
  - sel and cancel: sel wins if affordable; otherwise cancel.
- sel_i with insufficient credit: ignored; no state change.
- cancel_i: in CREDIT -> CHANGE. In IDLE, DISPENSE or CHANGE it is ignored.
- DISPENSE handshake:
  - disp_req_o = 1 from the first cycle in DISPENSE and held until disp_ack_i is sampled 1.
  - disp_req_o falls on the next edge. Exit to CHANGE if credit > 0, else to IDLE.
  - disp_ack_i is ignored in every other state. Ack already high on DISPENSE entry completes after one req cycle.
  - No timeout on ack.
- CHANGE sequence, repeated per unit:
  - eject_o high for CHANGE_PULSE_CYC cycles, then low for CHANGE_PULSE_CYC cycles.
  - credit decrements by 1 on the falling edge of each eject_o pulse.
  - After the gap that follows credit reaching 0 -> IDLE.
  - Total CHANGE duration = 2*CHANGE_PULSE_CYC*N cycles for N units.
- Outputs: credit_o is registered credit; busy_o and disp_req_o decode from the state register (Moore); eject_o is registered.
- Width rule: credit arithmetic is done in CW+1 bits; the overflow check compares against MAX_CREDIT in CW+1 bits.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined:
  - A counter counts cycles in CREDIT with no coin, sel or cancel; any of the three clears it.
  - At TIMEOUT_CYC -> CHANGE (auto-refund), as if cancel had been pressed.
  - The counter is cleared on entry to CREDIT.
- Undefined: no counter; credit is held indefinitely; the TIMEOUT_CYC parameter is unused.

Decomposition:
- Shared package vend_pkg holds:
  - state enum vend_state_t {IDLE, CREDIT, DISPENSE, CHANGE}, binary encoding;
  - coin code constants COIN_NONE = 2'b00, COIN_50 = 2'b01, COIN_100 = 2'b10.
- One sub-module, vend_change_pulser:
  - loads N units and produces the eject_o high/low pulse train;
  - issues a decrement strobe per pulse and a done flag;
  - is parameterised by CHANGE_PULSE_CYC.

Test Plan (PRICE=3, MAX_CREDIT=6, CHANGE_PULSE_CYC=4):
1. Coins 01, 10, then sel -> credit_o 1, 3; DISPENSE; disp_req_o = 1 next cycle; ack after 5 cycles -> req low next edge, credit 0, IDLE, eject_o never high.
2. Coins 10, 10, sel, ack -> credit 4, then 1 after sel; CHANGE: one eject_o pulse 4 cycles high, 4 low; credit 0; IDLE; busy_o high throughout DISPENSE+CHANGE.
3. Coins 10 x3, then 01 -> credit 6; fourth coin rejected: coin_reject_o single-cycle pulse, credit stays 6.
4. Credit 2, sel and coin 01 same cycle -> coin accepted, sel ignored (old credit 2 < 3), credit 3; sel next cycle -> DISPENSE.
5. Credit 5, cancel -> five eject pulses (40 cycles), credit 5 -> 0; a coin during CHANGE -> reject pulse; rst asserted mid-pulse -> eject_o 0 immediately, credit 0.
6. VEND_TIMEOUT_EN, TIMEOUT_CYC=20, credit 1, no activity -> CHANGE entered after 20 cycles, one eject pulse; with the macro undefined, credit still 1 after 100 cycles.
